// File: rtl/riscv_lsu_if.sv
// Core-request / response and memory-bus signal bundle for riscv_lsu.
// The slave modport is the LSU view; master is the core plus bus side.
interface riscv_lsu_if #(
    parameter int XLEN = 64,
    parameter int AW   = 64
) ();
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [2:0]        req_funct3;
    logic [AW-1:0]     req_addr;
    logic [XLEN-1:0]   req_wdata;
    logic              resp_valid;
    logic [XLEN-1:0]   resp_rdata;
    logic              resp_err;
    logic              busy;
    logic [AW-1:0]     bus_address;
    logic [XLEN-1:0]   bus_write_data;
    logic [XLEN/8-1:0] bus_byte_en;
    logic              bus_read_enable;
    logic              bus_write_enable;
    logic              bus_ready;
    logic [XLEN-1:0]   bus_read_data;

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata,
        input  bus_ready, bus_read_data,
        output req_ready, resp_valid, resp_rdata, resp_err, busy,
        output bus_address, bus_write_data, bus_byte_en,
        output bus_read_enable, bus_write_enable
    );

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata,
        output bus_ready, bus_read_data,
        input  req_ready, resp_valid, resp_rdata, resp_err, busy,
        input  bus_address, bus_write_data, bus_byte_en,
        input  bus_read_enable, bus_write_enable
    );
endinterface

// File: rtl/riscv_lsu.sv
// RISC-V load/store unit: one request at a time, lane placement, sign/zero
// extension, alignment/legality checking and a bounded bus wait.
module riscv_lsu #(
    parameter int XLEN    = 64,
    parameter int AW      = 64,
    parameter int TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       reset,
    riscv_lsu_if.slave lsu
);
    localparam int NB = XLEN / 8;
    localparam int OW = $clog2(NB);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t            state_q, state_d;
    logic              we_q, we_d;
    logic [2:0]        f3_q, f3_d;
    logic [AW-1:0]     addr_q, addr_d;
    logic [XLEN-1:0]   wdata_q, wdata_d;
    logic [15:0]       cnt_q, cnt_d;
    logic              err_q, err_d;
    logic [XLEN-1:0]   rdata_q, rdata_d;

    logic              req_bad;
    logic [3:0]        amask;
    logic [OW-1:0]     off_q;
    logic [XLEN-1:0]   shifted;
    logic [XLEN-1:0]   ext;
    logic              sbit;
    int unsigned       width;
    logic [NB-1:0]     lmask;
    logic [XLEN-1:0]   wrep;

    // Legality and alignment of the incoming request, judged before latching.
    always_comb begin
        amask   = (4'd1 << lsu.req_funct3[1:0]) - 4'd1;
        req_bad = (!lsu.req_we && lsu.req_funct3 == 3'b111)
               || (lsu.req_we && lsu.req_funct3[2])
               || (XLEN == 32 && (lsu.req_funct3[1:0] == 2'd3
                                  || (!lsu.req_we && lsu.req_funct3 == 3'b110)))
               || (|(lsu.req_addr[OW-1:0] & amask[OW-1:0]));
    end

    assign off_q   = addr_q[OW-1:0];
    assign shifted = lsu.bus_read_data >> {off_q, 3'b000};

    always_comb begin
        width = 8;
        sbit  = shifted[7];
        case (f3_q[1:0])
            2'd0: begin width = 8;    sbit = shifted[7];      end
            2'd1: begin width = 16;   sbit = shifted[15];     end
            2'd2: begin width = 32;   sbit = shifted[31];     end
            default: begin width = XLEN; sbit = shifted[XLEN-1]; end
        endcase
        ext = '0;
        for (int unsigned i = 0; i < XLEN; i++)
            ext[i] = (i < width) ? shifted[i] : (sbit & ~f3_q[2]);
    end

    always_comb begin
        lmask = '1;
        wrep  = wdata_q;
        case (f3_q[1:0])
            2'd0: begin lmask = NB'(4'h1); wrep = {NB{wdata_q[7:0]}};        end
            2'd1: begin lmask = NB'(4'h3); wrep = {(NB/2){wdata_q[15:0]}};   end
            2'd2: begin lmask = NB'(4'hF); wrep = {(NB/4){wdata_q[31:0]}};   end
            default: begin lmask = '1;    wrep = wdata_q;                   end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            f3_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            f3_q    <= f3_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        f3_d    = f3_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (lsu.req_valid) begin
                    we_d    = lsu.req_we;
                    f3_d    = lsu.req_funct3;
                    addr_d  = lsu.req_addr;
                    wdata_d = lsu.req_wdata;
                    err_d   = req_bad;
                    rdata_d = '0;
                    state_d = req_bad ? RESP : ACCESS;
                end
            end
            ACCESS: begin
                if (lsu.bus_ready) begin
                    rdata_d = we_q ? '0 : ext;
                    err_d   = 1'b0;
                    state_d = RESP;
                end else if (cnt_q == 16'(TIMEOUT - 1)) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            RESP: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        lsu.req_ready        = (state_q == IDLE);
        lsu.busy             = (state_q != IDLE);
        lsu.resp_valid       = (state_q == RESP);
        lsu.resp_rdata       = (state_q == RESP) ? rdata_q : '0;
        lsu.resp_err         = (state_q == RESP) && err_q;
        lsu.bus_read_enable  = (state_q == ACCESS) && !we_q;
        lsu.bus_write_enable = (state_q == ACCESS) && we_q;
        lsu.bus_address      = '0;
        lsu.bus_byte_en      = '0;
        lsu.bus_write_data   = '0;
        if (state_q == ACCESS) begin
            lsu.bus_address    = addr_q & ~AW'(NB - 1);
            lsu.bus_byte_en    = lmask << off_q;
            lsu.bus_write_data = we_q ? wrep : '0;
        end
    end
endmodule
